// File: rtl/pc_window_gen_pkg.sv
// -----------------------------------------------------------------------------
// cpu_sizes
//   Shared sizing constants and types for the PC window generator and the
//   blocks that reuse its fetch-block mask (e.g. the branch predictor).
//
//   XLEN          address width in bits
//   INSTR_WINDOW  PC slots presented per cycle (>= 1)
//   FETCH_BYTES   fetch-block / I-cache line size in bytes (power of two, >= 4)
//   RESET_VECTOR  base PC after reset
//   TRAP_VECTOR   redirect target for a misaligned redirect (PC_TRAP_EN builds)
// -----------------------------------------------------------------------------
package cpu_sizes;

  localparam int XLEN         = 32;
  localparam int INSTR_WINDOW = 4;
  localparam int FETCH_BYTES  = 16;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100;

  // Width of a byte offset inside one fetch block.
  localparam int OFF_W  = $clog2(FETCH_BYTES);
  // Width of a slot count 0..INSTR_WINDOW.
  localparam int SLOT_W = $clog2(INSTR_WINDOW + 1);

  typedef logic [XLEN-1:0]   pc_t;
  typedef logic [SLOT_W-1:0] slot_cnt_t;
  typedef logic [OFF_W-1:0]  blk_off_t;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } pcw_state_e;

endpackage

// File: rtl/pc_window_gen_if.sv
// -----------------------------------------------------------------------------
// pc_window_gen_if
//   Bundle between the PC window generator (slave) and its surroundings
//   (master: redirect logic plus the fetch/decode consumer).
//
//   PC_LD      master->slave  redirect request, loads PC_IN
//   PC_IN      master->slave  redirect target address
//   PC_STALL   master->slave  hold the current window
//   PC_ADV     master->slave  slots consumed this cycle
//   PC_OUT     slave->master  slot addresses, slot i = base + 4*i
//   PC_VALID   slave->master  per-slot valid mask
//   PC_NVALID  slave->master  popcount of PC_VALID
//   PC_TRAP    slave->master  misaligned-redirect pulse (only with PC_TRAP_EN)
// -----------------------------------------------------------------------------
interface pc_window_gen_if;
  import cpu_sizes::*;

  logic                          PC_LD;
  pc_t                           PC_IN;
  logic                          PC_STALL;
  slot_cnt_t                     PC_ADV;
  pc_t [INSTR_WINDOW-1:0]        PC_OUT;
  logic [INSTR_WINDOW-1:0]       PC_VALID;
  slot_cnt_t                     PC_NVALID;
`ifdef PC_TRAP_EN
  logic                          PC_TRAP;

  modport master (
    output PC_LD, PC_IN, PC_STALL, PC_ADV,
    input  PC_OUT, PC_VALID, PC_NVALID, PC_TRAP
  );

  modport slave (
    input  PC_LD, PC_IN, PC_STALL, PC_ADV,
    output PC_OUT, PC_VALID, PC_NVALID, PC_TRAP
  );
`else
  modport master (
    output PC_LD, PC_IN, PC_STALL, PC_ADV,
    input  PC_OUT, PC_VALID, PC_NVALID
  );

  modport slave (
    input  PC_LD, PC_IN, PC_STALL, PC_ADV,
    output PC_OUT, PC_VALID, PC_NVALID
  );
`endif

endinterface

// File: rtl/pc_window_gen_mask.sv
// -----------------------------------------------------------------------------
// pc_window_mask
//   Combinational fetch-block mask. Given the byte offset of a base PC inside
//   its fetch block, marks which of the INSTR_WINDOW consecutive slots stay
//   inside that same block, and counts them.
//
//   blk_off  in   base PC modulo FETCH_BYTES
//   valid    out  slot i valid iff blk_off + 4*i < FETCH_BYTES
//   nvalid   out  number of set bits in valid
//
//   Only the in-block offset is taken: the mask is evaluated before any
//   address wrap, so the upper PC bits never matter.
// -----------------------------------------------------------------------------
module pc_window_mask
  import cpu_sizes::*;
(
  input  blk_off_t                blk_off,
  output logic [INSTR_WINDOW-1:0] valid,
  output slot_cnt_t               nvalid
);

  for (genvar gi = 0; gi < INSTR_WINDOW; gi++) begin : g_slot
    assign valid[gi] = (int'(blk_off) + 4 * gi) < FETCH_BYTES;
  end

  always_comb begin
    nvalid = '0;
    for (int i = 0; i < INSTR_WINDOW; i++) begin
      nvalid = nvalid + slot_cnt_t'(valid[i]);
    end
  end

endmodule

// File: rtl/pc_window_gen.sv
// -----------------------------------------------------------------------------
// pc_window_gen
//   Multi-issue program counter. Holds one base PC and presents INSTR_WINDOW
//   consecutive instruction addresses per cycle; the base advances by the
//   number of slots the consumer actually accepted (saturated to the number
//   of valid slots). A redirect costs one bubble cycle. Windows never cross
//   a FETCH_BYTES boundary.
//
//   PC_CLK    in   clock, rising edge
//   PC_RST_N  in   asynchronous active-low reset
//   pcw       slave modport of pc_window_gen_if (LD/IN/STALL/ADV in,
//             OUT/VALID/NVALID and optional TRAP out)
//
//   Optional build macro PC_TRAP_EN: a misaligned redirect loads TRAP_VECTOR
//   and pulses PC_TRAP during the following (bubble) cycle. Without it the
//   low two bits of the redirect target are simply cleared.
// -----------------------------------------------------------------------------
module pc_window_gen
  import cpu_sizes::*;
(
  input  logic              PC_CLK,
  input  logic              PC_RST_N,
  pc_window_gen_if.slave    pcw
);

  pcw_state_e state_reg, state_next;
  pc_t        base_reg, base_next;

  logic [INSTR_WINDOW-1:0] mask_valid;
  slot_cnt_t               mask_nvalid;
  slot_cnt_t               adv_eff;
  pc_t                     ld_target;

  pc_window_mask u_mask (
    .blk_off (base_reg[OFF_W-1:0]),
    .valid   (mask_valid),
    .nvalid  (mask_nvalid)
  );

  // Redirect target selection.
`ifdef PC_TRAP_EN
  logic ld_misaligned;
  logic trap_reg, trap_next;

  assign ld_misaligned = |pcw.PC_IN[1:0];
  assign ld_target     = ld_misaligned ? TRAP_VECTOR : pcw.PC_IN;
`else
  assign ld_target     = pcw.PC_IN & ~pc_t'(3);
`endif

  // Consumer may over-report; never step past the last valid slot.
  assign adv_eff = (pcw.PC_ADV > mask_nvalid) ? mask_nvalid : pcw.PC_ADV;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge PC_CLK or negedge PC_RST_N) begin
    if (!PC_RST_N) begin
      state_reg <= BOOT;
      base_reg  <= RESET_VECTOR;
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
    end
  end

`ifdef PC_TRAP_EN
  // The pulse lines up with the bubble that follows the offending redirect.
  always_ff @(posedge PC_CLK or negedge PC_RST_N) begin
    if (!PC_RST_N) begin
      trap_reg <= 1'b0;
    end else begin
      trap_reg <= trap_next;
    end
  end

  always_comb begin
    trap_next = 1'b0;
    if ((state_reg == RUN || state_reg == BUBBLE) && pcw.PC_LD) begin
      trap_next = ld_misaligned;
    end
  end

  assign pcw.PC_TRAP = trap_reg;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-base logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (pcw.PC_LD) begin
          base_next  = ld_target;
          state_next = BUBBLE;
        end else if (!pcw.PC_STALL) begin
          base_next  = base_reg + (pc_t'(adv_eff) << 2);
        end
      end
      BUBBLE: begin
        // Stall does not stretch the bubble; only a fresh redirect does.
        if (pcw.PC_LD) begin
          base_next  = ld_target;
          state_next = BUBBLE;
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = BOOT;
        base_next  = RESET_VECTOR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Slot addresses follow the base in every state, including reset and bubble.
  for (genvar gi = 0; gi < INSTR_WINDOW; gi++) begin : g_out
    assign pcw.PC_OUT[gi] = base_reg + pc_t'(4 * gi);
  end

  always_comb begin
    pcw.PC_VALID  = '0;
    pcw.PC_NVALID = '0;
    if (state_reg == RUN) begin
      pcw.PC_VALID  = mask_valid;
      pcw.PC_NVALID = mask_nvalid;
    end
  end

endmodule

// File: tb/tb_pc_window_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_window_gen
//   Directed bench for pc_window_gen. Each step drives inputs, queues the
//   expected post-edge window, then pops and checks it after the edge.
// -----------------------------------------------------------------------------
module tb_pc_window_gen;
  import cpu_sizes::*;

  logic pc_clk = 1'b0;
  logic pc_rst_n = 1'b0;

  always #5 pc_clk = ~pc_clk;

  pc_window_gen_if pcw_if ();

  pc_window_gen dut (
    .PC_CLK   (pc_clk),
    .PC_RST_N (pc_rst_n),
    .pcw      (pcw_if)
  );

  typedef struct {
    string tag;
    pc_t   base;
    bit    run;
    bit    trap;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef PC_TRAP_EN
  localparam pc_t MIS_BASE = TRAP_VECTOR;
  localparam bit  MIS_TRAP = 1'b1;
`else
  localparam pc_t MIS_BASE = 32'h0000_0204;
  localparam bit  MIS_TRAP = 1'b0;
`endif

  // Slots left before the end of the fetch block, capped at the window size.
  function automatic int model_n(pc_t b);
    int room;
    room = (FETCH_BYTES - int'(b[OFF_W-1:0])) / 4;
    return (room < INSTR_WINDOW) ? room : INSTR_WINDOW;
  endfunction

  task automatic check_out();
    exp_t                    e;
    int                      n;
    logic [INSTR_WINDOW-1:0] ev;
    pc_t                     ea;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    n = e.run ? model_n(e.base) : 0;
    ev = '0;
    for (int i = 0; i < n; i++) ev[i] = 1'b1;
    for (int i = 0; i < INSTR_WINDOW; i++) begin
      ea = e.base + pc_t'(4 * i);
      checks++;
      assert (pcw_if.PC_OUT[i] === ea) else begin
        errors++;
        $error("FAIL %s out[%0d] got %h exp %h", e.tag, i, pcw_if.PC_OUT[i], ea);
      end
    end
    checks++;
    assert (pcw_if.PC_VALID === ev) else begin
      errors++;
      $error("FAIL %s valid got %b exp %b", e.tag, pcw_if.PC_VALID, ev);
    end
    checks++;
    assert (pcw_if.PC_NVALID === slot_cnt_t'(n)) else begin
      errors++;
      $error("FAIL %s nvalid got %0d exp %0d", e.tag, pcw_if.PC_NVALID, n);
    end
`ifdef PC_TRAP_EN
    checks++;
    assert (pcw_if.PC_TRAP === e.trap) else begin
      errors++;
      $error("FAIL %s trap got %b exp %b", e.tag, pcw_if.PC_TRAP, e.trap);
    end
`endif
    $display("txn %-10s base=%h valid=%b nvalid=%0d", e.tag, pcw_if.PC_OUT[0],
             pcw_if.PC_VALID, pcw_if.PC_NVALID);
  endtask

  // Check the current (unclocked) outputs.
  task automatic expect_now(string tag, pc_t eb, bit run, bit trap);
    sb_q.push_back('{tag: tag, base: eb, run: run, trap: trap});
    check_out();
  endtask

  // Drive one cycle of inputs and check the window after the edge.
  task automatic step(string tag, logic ld, pc_t pin, logic stall, slot_cnt_t adv,
                      pc_t eb, bit run, bit trap);
    pcw_if.PC_LD    = ld;
    pcw_if.PC_IN    = pin;
    pcw_if.PC_STALL = stall;
    pcw_if.PC_ADV   = adv;
    sb_q.push_back('{tag: tag, base: eb, run: run, trap: trap});
    @(posedge pc_clk);
    #1;
    check_out();
  endtask

  initial begin
    pcw_if.PC_LD    = 1'b0;
    pcw_if.PC_IN    = '0;
    pcw_if.PC_STALL = 1'b0;
    pcw_if.PC_ADV   = '0;

    // Reset and boot.
    repeat (3) @(posedge pc_clk);
    #1;
    expect_now("reset", RESET_VECTOR, 1'b0, 1'b0);
    pc_rst_n = 1'b1;
    expect_now("boot", RESET_VECTOR, 1'b0, 1'b0);
    step("run0",    1'b0, '0, 1'b0, 3'd0, 32'h0000_0000, 1'b1, 1'b0);

    // Partial advance, then saturating over-report.
    step("adv3",    1'b0, '0, 1'b0, 3'd3, 32'h0000_000C, 1'b1, 1'b0);
    step("adv4sat", 1'b0, '0, 1'b0, 3'd4, 32'h0000_0010, 1'b1, 1'b0);
    step("stall",   1'b0, '0, 1'b1, 3'd2, 32'h0000_0010, 1'b1, 1'b0);
    step("adv0",    1'b0, '0, 1'b0, 3'd0, 32'h0000_0010, 1'b1, 1'b0);

    // Redirect, bubble, back-to-back redirects.
    step("ld208",   1'b1, 32'h0000_0208, 1'b0, 3'd0, 32'h0000_0208, 1'b0, 1'b0);
    step("post208", 1'b0, '0,            1'b0, 3'd3, 32'h0000_0208, 1'b1, 1'b0);
    step("ld300",   1'b1, 32'h0000_0300, 1'b0, 3'd0, 32'h0000_0300, 1'b0, 1'b0);
    step("ld404",   1'b1, 32'h0000_0404, 1'b0, 3'd0, 32'h0000_0404, 1'b0, 1'b0);
    step("bubstall",1'b0, '0,            1'b1, 3'd0, 32'h0000_0404, 1'b1, 1'b0);
    step("adv2",    1'b0, '0,            1'b0, 3'd2, 32'h0000_040C, 1'b1, 1'b0);

    // Load beats stall.
    step("ldstall", 1'b1, 32'h0000_0040, 1'b1, 3'd2, 32'h0000_0040, 1'b0, 1'b0);
    step("post40",  1'b0, '0,            1'b0, 3'd0, 32'h0000_0040, 1'b1, 1'b0);

    // Wrap at the top of the address space.
    step("ldfff0",  1'b1, 32'hFFFF_FFF0, 1'b0, 3'd0, 32'hFFFF_FFF0, 1'b0, 1'b0);
    step("runfff0", 1'b0, '0,            1'b0, 3'd0, 32'hFFFF_FFF0, 1'b1, 1'b0);
    step("wrap4",   1'b0, '0,            1'b0, 3'd4, 32'h0000_0000, 1'b1, 1'b0);
    step("ldfff8",  1'b1, 32'hFFFF_FFF8, 1'b0, 3'd0, 32'hFFFF_FFF8, 1'b0, 1'b0);
    step("runfff8", 1'b0, '0,            1'b0, 3'd0, 32'hFFFF_FFF8, 1'b1, 1'b0);
    step("wrapsat", 1'b0, '0,            1'b0, 3'd4, 32'h0000_0000, 1'b1, 1'b0);

    // Misaligned redirect.
    step("ldmis",   1'b1, 32'h0000_0206, 1'b0, 3'd0, MIS_BASE, 1'b0, MIS_TRAP);
    step("postmis", 1'b0, '0,            1'b0, 3'd0, MIS_BASE, 1'b1, 1'b0);
    step("advmis",  1'b0, '0,            1'b0, 3'd1, MIS_BASE + 32'd4, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a bubble.
    step("ld500",   1'b1, 32'h0000_0500, 1'b0, 3'd0, 32'h0000_0500, 1'b0, 1'b0);
    pcw_if.PC_LD = 1'b0;
    #2;
    pc_rst_n = 1'b0;
    #1;
    expect_now("asyncrst", RESET_VECTOR, 1'b0, 1'b0);
    repeat (2) @(posedge pc_clk);
    #1;
    pc_rst_n = 1'b1;
    expect_now("reboot", RESET_VECTOR, 1'b0, 1'b0);
    step("rerun",   1'b0, '0, 1'b0, 3'd0, RESET_VECTOR, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_window_gen.md
Name: pc_window_gen

Overview:
- Multi-issue program-counter unit. Holds one base PC and presents INSTR_WINDOW consecutive instruction addresses to fetch/decode each cycle.
- The consumer reports how many slots it accepted. The base then advances by that count, not by a fixed window.
- Supports branch/jump redirect with a one-cycle bubble, stall, and a fetch-block boundary mask so no window straddles an I-cache line.
- Sits between the branch/jump target logic and the instruction memory/decode front end.

Parameters:
- XLEN, 32, address width in bits.
- INSTR_WINDOW, 4, number of PC slots presented per cycle; must be >= 1.
- FETCH_BYTES, 16, fetch-block size in bytes; power of two, >= 4.
- RESET_VECTOR, 32'h0000_0000, base PC after reset.
- TRAP_VECTOR, 32'h0000_0100, redirect target on a misaligned redirect (optional feature only).

Ports:
- PC_CLK  in  1  clock; all state updates on its rising edge.
- PC_RST_N  in  1  reset, asynchronous, active-low.
- PC_LD  in  1  redirect request; loads PC_IN.
- PC_IN  in  XLEN  redirect target address.
- PC_STALL  in  1  hold the current window; no advance.
- PC_ADV  in  $clog2(INSTR_WINDOW+1)  number of slots consumed this cycle.
- PC_OUT  out  INSTR_WINDOW x XLEN  slot addresses; slot i = base + 4*i.
- PC_VALID  out  INSTR_WINDOW  per-slot valid mask.
- PC_NVALID  out  $clog2(INSTR_WINDOW+1)  popcount of PC_VALID.
- PC_TRAP  out  1  misaligned-redirect pulse; exists only with PC_TRAP_EN.

Behaviour:
- State machine: BOOT, RUN, BUBBLE.
- Reset (PC_RST_N=0, any time, including mid-redirect): state=BOOT, base=RESET_VECTOR, PC_VALID=0, PC_NVALID=0, PC_TRAP=0. PC_OUT still shows RESET_VECTOR+4*i.
- BOOT -> RUN on the first clock edge after reset deasserts. No window is valid in BOOT.
- In RUN:
  - Slot i is valid iff (base + 4*i) lies in the same FETCH_BYTES block as base, i.e. (base mod FETCH_BYTES) + 4*i < FETCH_BYTES.
  - PC_NVALID = count of valid slots. This is combinational from base; zero latency.
- Priority each edge in RUN: PC_LD > PC_STALL > PC_ADV.
  - PC_LD=1: base <= PC_IN with bits [1:0] cleared; state <= BUBBLE. PC_STALL and PC_ADV are ignored that cycle.
  - PC_STALL=1: base unchanged.
  - Otherwise: base <= base + 4*min(PC_ADV, PC_NVALID). Over-reporting saturates to PC_NVALID. PC_ADV=0 holds base.
- BUBBLE lasts exactly one cycle: PC_VALID=0 and PC_NVALID=0, and PC_OUT already shows the new base. PC_ADV is ignored.
  - Next state is RUN, unless PC_LD=1 in BUBBLE: then load the new target and stay in BUBBLE one more cycle.
  - PC_STALL in BUBBLE does not extend the bubble.
- Arithmetic is modulo 2^XLEN. Wrap from 0xFFFF_FFFC to 0x0000_0000 is legal and silent.
- Slot addresses also wrap modulo 2^XLEN. Block-boundary masking is computed before wrap.
- Registered state: base and state only. All outputs are combinational from these, except PC_TRAP, which is registered.

Optional Feature:
- Macro: PC_TRAP_EN.
- Defined:
  - PC_LD with PC_IN[1:0] != 0 loads TRAP_VECTOR instead of PC_IN.
  - PC_TRAP pulses high for exactly the following cycle, concurrent with the BUBBLE state.
  - Aligned redirects behave as without the macro.
- Undefined:
  - PC_TRAP port and TRAP_VECTOR logic are absent.
  - Bits [1:0] of PC_IN are silently cleared.

Decomposition:
- Package cpu_sizes gains INSTR_WINDOW (existing), FETCH_BYTES, XLEN, RESET_VECTOR, and TRAP_VECTOR.
- Package cpu_sizes also gains typedefs pc_t (logic [XLEN-1:0]), slot_cnt_t (logic [$clog2(INSTR_WINDOW+1)-1:0]), and enum pcw_state_e {BOOT, RUN, BUBBLE}.
- One sub-module is natural: pc_window_mask. It is combinational and maps base to PC_VALID/PC_NVALID. It is reused by the branch predictor.

Test Plan:
- Reset/boot: hold PC_RST_N=0 for 3 cycles, release -> one cycle PC_VALID=0, then PC_OUT={0,4,8,C}, PC_VALID=4'b1111, PC_NVALID=4.
- Partial advance: base=0, PC_ADV=3 -> base=0xC, PC_VALID=4'b0001, PC_NVALID=1; PC_ADV=4 next -> saturates, base=0x10.
- Redirect and bubble:
  - PC_LD=1, PC_IN=0x208 in RUN -> next cycle BUBBLE with PC_OUT[0]=0x208 and PC_VALID=0.
  - Following cycle: PC_VALID=4'b0011.
  - Back-to-back PC_LD in BUBBLE extends the bubble.
- Stall vs. load precedence: PC_STALL=1 with PC_ADV=2 -> base held; PC_STALL=1 with PC_LD=1, PC_IN=0x40 -> base=0x40.
- Wrap: base=0xFFFF_FFF0, PC_ADV=4 -> base=0x0000_0000. Async reset asserted mid-BUBBLE -> immediately PC_VALID=0 and base=RESET_VECTOR without a clock edge.
- PC_TRAP_EN: PC_LD with PC_IN=0x0000_0206 -> base=0x100, PC_TRAP=1 for one cycle. Without the macro -> base=0x204.
